// File: rtl/permute_round_controller.sv
// Slice-serial permutation sequencer: walks ROUNDS x SLICES compute cycles per job
// and hands the result off through a valid/ready handshake.
module permute_round_controller #(
  parameter int ROUNDS = 24,
  parameter int SLICES = 64,
  parameter int RW     = 5,
  parameter int SW     = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          out_ready,
  output logic          ready,
  output logic          ld_in,
  output logic          sel_fb,
  output logic          ld_state,
  output logic [SW-1:0] slice_idx,
  output logic [RW-1:0] round_idx,
  output logic          ld_out,
  output logic          out_valid,
  output logic          done
);

  // state   | meaning
  // IDLE    | waiting for start, ready high
  // LOAD    | capture external input into the state register
  // COMPUTE | one slice per cycle, ROUNDS*SLICES cycles
  // OUTPUT  | ld_out on entry, then out_valid until accepted
  // FINISH  | done pulse, back to IDLE
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_COMPUTE = 3'd2;
  localparam logic [2:0] S_OUTPUT  = 3'd3;
  localparam logic [2:0] S_FINISH  = 3'd4;

  localparam logic [SW-1:0] SLICE_LAST = SW'(SLICES - 1);
  localparam logic [RW-1:0] ROUND_LAST = RW'(ROUNDS - 1);

  logic [2:0]    state_q, state_d;
  logic [SW-1:0] slice_q, slice_d;
  logic [RW-1:0] round_q, round_d;
  logic          vld_q, vld_d;

  always_comb begin
    state_d = state_q;
    slice_d = '0;
    round_d = '0;
    vld_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = S_COMPUTE;
      end
      S_COMPUTE: begin
        // >= rather than == so an out-of-range code wraps instead of running on
        slice_d = (slice_q >= SLICE_LAST) ? '0 : slice_q + 1'b1;
        round_d = round_q;
        if (slice_q == SLICE_LAST) begin
          round_d = (round_q >= ROUND_LAST) ? '0 : round_q + 1'b1;
        end
        if (slice_q == SLICE_LAST && round_q == ROUND_LAST) begin
          state_d = S_OUTPUT;
          slice_d = '0;
          round_d = '0;
        end
      end
      S_OUTPUT: begin
        // vld_q low marks the first OUTPUT cycle, when the result is loaded
        if (vld_q && out_ready) state_d = S_FINISH;
        else                    vld_d   = 1'b1;
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      slice_q <= '0;
      round_q <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slice_q <= slice_d;
      round_q <= round_d;
      vld_q   <= vld_d;
    end
  end

  assign ready     = (state_q == S_IDLE);
  assign ld_in     = (state_q == S_LOAD);
  assign sel_fb    = (state_q == S_COMPUTE);
  assign ld_state  = (state_q == S_COMPUTE);
  assign slice_idx = (state_q == S_COMPUTE) ? slice_q : '0;
  assign round_idx = (state_q == S_COMPUTE) ? round_q : '0;
  assign ld_out    = (state_q == S_OUTPUT) && !vld_q;
  assign out_valid = (state_q == S_OUTPUT) && vld_q;
  assign done      = (state_q == S_FINISH);

endmodule

// File: tb/tb_permute_round_controller.sv
// Directed bench: a 2x4 instance for sequencing detail and a default 24x64
// instance for back-to-back job timing.
module tb_permute_round_controller;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       s_rst, s_start, s_out_ready;
  logic       s_ready, s_ld_in, s_sel_fb, s_ld_state, s_ld_out, s_out_valid, s_done;
  logic [1:0] s_slice_idx;
  logic [0:0] s_round_idx;

  logic       d_rst, d_start, d_out_ready;
  logic       d_ready, d_ld_in, d_sel_fb, d_ld_state, d_ld_out, d_out_valid, d_done;
  logic [5:0] d_slice_idx;
  logic [4:0] d_round_idx;

  permute_round_controller #(.ROUNDS(2), .SLICES(4), .RW(1), .SW(2)) dut_s (
    .clk(clk), .rst(s_rst), .start(s_start), .out_ready(s_out_ready),
    .ready(s_ready), .ld_in(s_ld_in), .sel_fb(s_sel_fb), .ld_state(s_ld_state),
    .slice_idx(s_slice_idx), .round_idx(s_round_idx), .ld_out(s_ld_out),
    .out_valid(s_out_valid), .done(s_done)
  );

  permute_round_controller dut_d (
    .clk(clk), .rst(d_rst), .start(d_start), .out_ready(d_out_ready),
    .ready(d_ready), .ld_in(d_ld_in), .sel_fb(d_sel_fb), .ld_state(d_ld_state),
    .slice_idx(d_slice_idx), .round_idx(d_round_idx), .ld_out(d_ld_out),
    .out_valid(d_out_valid), .done(d_done)
  );

  int checks = 0;
  int errors = 0;

  // {ready, ld_in, sel_fb, ld_state, ld_out, out_valid, done}
  localparam logic [6:0] C_IDLE  = 7'b1000000;
  localparam logic [6:0] C_LOAD  = 7'b0100000;
  localparam logic [6:0] C_COMP  = 7'b0011000;
  localparam logic [6:0] C_LDOUT = 7'b0000100;
  localparam logic [6:0] C_VALID = 7'b0000010;
  localparam logic [6:0] C_DONE  = 7'b0000001;

  function automatic logic [6:0] s_ctrl();
    return {s_ready, s_ld_in, s_sel_fb, s_ld_state, s_ld_out, s_out_valid, s_done};
  endfunction

  function automatic logic [6:0] d_ctrl();
    return {d_ready, d_ld_in, d_sel_fb, d_ld_state, d_ld_out, d_out_valid, d_done};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_s(input string tag, input logic [6:0] ctrl, input int sl, input int rd);
    chk({tag, "_ctrl"}, {25'd0, s_ctrl()}, {25'd0, ctrl});
    chk({tag, "_slice"}, {30'd0, s_slice_idx}, sl);
    chk({tag, "_round"}, {31'd0, s_round_idx}, rd);
  endtask

  // n compute cycles; start is raised after the check at indices pa and pb
  task automatic compute_cycles(input int n, input int pa, input int pb);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk_s($sformatf("compute%0d", i), C_COMP, i % 4, i / 4);
      s_start = (i == pa || i == pb);
    end
  endtask

  task automatic tail_handshake(input string tag);
    @(negedge clk); chk_s({tag, "_ldout"}, C_LDOUT, 0, 0);
    @(negedge clk); chk_s({tag, "_valid"}, C_VALID, 0, 0);
    @(negedge clk); chk_s({tag, "_done"},  C_DONE,  0, 0);
    @(negedge clk); chk_s({tag, "_idle"},  C_IDLE,  0, 0);
  endtask

  int cyc, ndone, ncomp, max_s, max_r;
  int dc[3];

  initial begin
    s_rst = 1'b0; s_start = 1'b1; s_out_ready = 1'b1;
    d_rst = 1'b0; d_start = 1'b0; d_out_ready = 1'b1;

    // reset held with start high: must stay idle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_s($sformatf("reset%0d", i), C_IDLE, 0, 0);
    end
    chk("d_reset_ctrl", {25'd0, d_ctrl()}, {25'd0, C_IDLE});
    s_rst = 1'b1;

    // single job straight out of reset
    @(negedge clk); chk_s("job1_load", C_LOAD, 0, 0);
    s_start = 1'b0;
    compute_cycles(8, -1, -1);
    s_start = 1'b0;
    tail_handshake("job1");

    // backpressure
    s_start = 1'b1; s_out_ready = 1'b0;
    @(negedge clk); chk_s("bp_load", C_LOAD, 0, 0);
    s_start = 1'b0;
    compute_cycles(8, -1, -1);
    s_start = 1'b0;
    @(negedge clk); chk_s("bp_ldout", C_LDOUT, 0, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); chk_s($sformatf("bp_hold%0d", i), C_VALID, 0, 0);
    end
    s_out_ready = 1'b1;
    @(negedge clk); chk_s("bp_done", C_DONE, 0, 0);
    @(negedge clk); chk_s("bp_idle", C_IDLE, 0, 0);

    // start pulses while busy are ignored
    s_start = 1'b1;
    @(negedge clk); chk_s("busy_load", C_LOAD, 0, 0);
    s_start = 1'b0;
    compute_cycles(8, 3, 7);
    s_start = 1'b0;
    tail_handshake("busy");
    @(negedge clk); chk_s("busy_no_requeue", C_IDLE, 0, 0);

    // async reset mid-job at round 1, slice 2
    s_start = 1'b1;
    @(negedge clk); chk_s("abort_load", C_LOAD, 0, 0);
    s_start = 1'b0;
    compute_cycles(7, -1, -1);
    s_start = 1'b0;
    s_rst = 1'b0;
    #1 chk_s("abort_async", C_IDLE, 0, 0);
    @(negedge clk); chk_s("abort_nodone", C_IDLE, 0, 0);
    s_rst = 1'b1; s_start = 1'b1;
    @(negedge clk); chk_s("restart_load", C_LOAD, 0, 0);
    s_start = 1'b0;
    compute_cycles(8, -1, -1);
    s_start = 1'b0;
    tail_handshake("restart");

    // default 24x64, start and out_ready held high
    d_rst = 1'b1; d_start = 1'b1;
    cyc = 0; ndone = 0; ncomp = 0; max_s = 0; max_r = 0;
    dc[0] = 0; dc[1] = 0; dc[2] = 0;
    while (ndone < 3 && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      if (d_ld_state && ndone == 0) ncomp++;
      if (int'(d_slice_idx) > max_s) max_s = int'(d_slice_idx);
      if (int'(d_round_idx) > max_r) max_r = int'(d_round_idx);
      if (d_done) begin
        dc[ndone] = cyc;
        ndone++;
      end
    end
    chk("d_done_count", ndone, 3);
    chk("d_compute_cycles", ncomp, 1536);
    chk("d_spacing1", dc[1] - dc[0], 1541);
    chk("d_spacing2", dc[2] - dc[1], 1541);
    chk("d_max_slice", max_s, 63);
    chk("d_max_round", max_r, 23);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/permute_round_controller.md
Name: permute_round_controller

Overview:
- Sequencing FSM for the permute datapath: drives the load enables of the state and output registers, the source-select mux, and the slice/round indices for a slice-serial permutation.
- One job is `ROUNDS` rounds × `SLICES` slices, one slice per cycle.
- Sits between the encoder top-level, which issues start and consumes the result through a valid/ready handshake, and the permute register and slice-logic datapath.

Parameters:
- ROUNDS, 24, number of permutation rounds per job (≥1)
- SLICES, 64, slices processed per round, one per cycle (≥2)
- RW, 5, round index width; must satisfy 2^RW ≥ ROUNDS
- SW, 6, slice index width; must satisfy 2^SW ≥ SLICES

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- start  input  1  job request, sampled only in IDLE
- out_ready  input  1  consumer accepts the result when high with out_valid
- ready  output  1  controller idle, start will be accepted
- ld_in  output  1  load enable for the input/state register from the external input
- sel_fb  output  1  datapath mux select: 0 = external input, 1 = feedback from slice logic
- ld_state  output  1  state register load enable, one slice per cycle
- slice_idx  output  SW  slice currently addressed
- round_idx  output  RW  round currently executing, also the round-constant index
- ld_out  output  1  output register load enable, one-cycle pulse
- out_valid  output  1  result held in the output register is valid
- done  output  1  one-cycle pulse on completed output handshake

Behaviour:
- States: IDLE, LOAD, COMPUTE, OUTPUT, FINISH. Outputs are Moore-decoded from state and counters, with no combinational input-to-output paths.
- Reset (rst=0, asynchronous): state=IDLE, slice_idx=0, round_idx=0. Resulting outputs: ready=1, all other outputs 0. Reset asserted mid-job aborts immediately; no done pulse; the next job starts clean.
- IDLE: ready=1. start=1 → LOAD. start=0 → stay.
- LOAD (1 cycle): ld_in=1, sel_fb=0. Counters cleared to 0. Next state COMPUTE.
- COMPUTE: ld_state=1 and sel_fb=1 every cycle.
  - slice_idx increments each cycle.
  - At slice_idx=SLICES-1, slice_idx wraps to 0 and round_idx increments.
  - At round_idx=ROUNDS-1 and slice_idx=SLICES-1: go to OUTPUT, counters cleared.
  - Stays exactly ROUNDS*SLICES cycles.
- OUTPUT:
  - First cycle: ld_out=1 (exactly one pulse per job).
  - out_valid=1 from the cycle after entry until handshake.
  - out_valid & out_ready → FINISH. out_ready low holds OUTPUT indefinitely; out_valid stays high and ld_out stays 0.
  - out_ready already high on the first out_valid cycle completes the handshake that cycle.
- FINISH (1 cycle): done=1 → IDLE.
- Latency: start sampled at edge N gives:
  - LOAD at cycle N+1
  - COMPUTE at N+2 .. N+1+ROUNDS*SLICES
  - ld_out at N+2+ROUNDS*SLICES
  - earliest out_valid at N+3+ROUNDS*SLICES
  - earliest done at N+4+ROUNDS*SLICES
- start outside IDLE is ignored, not queued.
- start held high continuously gives back-to-back jobs with exactly one IDLE cycle between FINISH and LOAD.
- Counters never exceed SLICES-1 / ROUNDS-1. Unused high counter codes are unreachable; if forced, the next increment wraps to 0.
- Illegal state encodings recover to IDLE on the next clock.
- Index outputs are 0 in IDLE, LOAD, OUTPUT and FINISH.

Test Plan:
- Reset: hold rst=0 for 3 cycles with start=1 → ready=1, every other output 0, no LOAD entered. Release rst → LOAD on the next edge.
- Single job with ROUNDS=2, SLICES=4 and out_ready=1:
  - start pulse → ld_in for 1 cycle.
  - 8 COMPUTE cycles with slice_idx 0,1,2,3,0,1,2,3 and round_idx 0,0,0,0,1,1,1,1.
  - Then ld_out once, out_valid 1 cycle, done 1 cycle, ready back high.
- Backpressure: same job with out_ready=0 for 10 cycles → out_valid held 10 cycles, ld_out pulsed once only. out_ready=1 → done on the next cycle.
- Start during busy: pulse start at COMPUTE cycles 3 and 7 → exactly one job completes and ready stays 0 throughout.
- Mid-job reset: assert rst=0 at round_idx=1, slice_idx=2 → asynchronous return to IDLE, no done pulse. A subsequent start runs a full 8-cycle compute from indices 0/0.
- Defaults (24×64): continuous start=1 and out_ready=1 → 1536 COMPUTE cycles per job. done pulses spaced 1541 cycles apart (LOAD + 1536 COMPUTE + OUTPUT + out_valid + FINISH + IDLE).
